// File: rtl/shift_reg_pkg.sv
// Shared mode/direction encodings for the multi-mode shift register.
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_reg_multi_if.sv
// Load/shift control and register outputs of shift_reg_multi.
// SHIFT_REG_MULTI_EXT_TICK_EN adds the external tick input i_tick.
interface shift_reg_multi_if #(
    parameter int unsigned WIDTH = 16
) ();

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] i_wr_data;
    logic             i_wr_data_en;
    logic             i_wr_bit;
    logic [1:0]       i_mode;
    logic             i_dir;
`ifdef SHIFT_REG_MULTI_EXT_TICK_EN
    logic             i_tick;
`endif
    logic             o_out;
    logic [WIDTH-1:0] o_whole_reg;
    logic [CNT_W-1:0] o_shift_cnt;
    logic             o_wrap;

    modport master (
        output i_wr_data, i_wr_data_en, i_wr_bit, i_mode, i_dir,
`ifdef SHIFT_REG_MULTI_EXT_TICK_EN
        output i_tick,
`endif
        input  o_out, o_whole_reg, o_shift_cnt, o_wrap
    );

    modport slave (
        input  i_wr_data, i_wr_data_en, i_wr_bit, i_mode, i_dir,
`ifdef SHIFT_REG_MULTI_EXT_TICK_EN
        input  i_tick,
`endif
        output o_out, o_whole_reg, o_shift_cnt, o_wrap
    );

endinterface

// File: rtl/rate_tick.sv
// Free-running divider producing a one-cycle tick every DIV = F_CLK/F_SHIFT clocks.
// i_clr restarts the period so the next tick lands DIV clocks after the clear.
module rate_tick #(
    parameter int unsigned F_CLK   = 50_000_000,
    parameter int unsigned F_SHIFT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned DIV_RAW = (F_SHIFT == 0) ? 1 : F_CLK / F_SHIFT;
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_q, div_d;

    assign o_tick = (div_q == LAST);

    // Next divider count: wrap on tick, restart on clear.
    always_comb begin
        div_d = div_q + CNT_W'(1);
        if (i_clr || o_tick) begin
            div_d = '0;
        end
    end

    // Divider state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/shift_reg_multi.sv
// Parametrised shift/rotate register with shift counter and wrap pulse.
// SHIFT_REG_MULTI_EXT_TICK_EN: shift timing comes from bus.i_tick instead of
// the internal rate_tick divider.
module shift_reg_multi
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned F_CLK   = 50_000_000,
    parameter int unsigned F_SHIFT = 2
) (
    input logic              clk,
    input logic              rst_n,
    shift_reg_multi_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             stepped;

`ifdef SHIFT_REG_MULTI_EXT_TICK_EN
    assign tick = bus.i_tick;
`else
    rate_tick #(
        .F_CLK   (F_CLK),
        .F_SHIFT (F_SHIFT)
    ) u_rate_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (bus.i_wr_data_en),
        .o_tick (tick)
    );
`endif

    // Next register/count: load beats tick; mode and dir only matter on a tick.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        stepped = 1'b0;
        if (bus.i_wr_data_en) begin
            shreg_d = bus.i_wr_data;
            cnt_d   = '0;
        end else if (tick) begin
            case (bus.i_mode)
                MODE_SHIFT: begin
                    stepped = 1'b1;
                    if (bus.i_dir == DIR_RIGHT) begin
                        shreg_d = {bus.i_wr_bit, shreg_q[WIDTH-1:1]};
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], bus.i_wr_bit};
                    end
                end
                MODE_ROTATE: begin
                    stepped = 1'b1;
                    if (bus.i_dir == DIR_RIGHT) begin
                        shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
                    end
                end
                default: ;  // HOLD and reserved encoding
            endcase
            if (stepped) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Register, count and wrap-pulse state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.o_out       = (bus.i_dir == DIR_RIGHT) ? shreg_q[0] : shreg_q[WIDTH-1];
    assign bus.o_whole_reg = shreg_q;
    assign bus.o_shift_cnt = cnt_q;
    assign bus.o_wrap      = wrap_q;

endmodule
